// File: rtl/grey_code_rx.sv
// -----------------------------------------------------------------------------
// grey_code_rx
//   Receive side of the gray-code counter link. Samples a gray-coded bus driven
//   from another clock domain, passes every bit through a plain flop
//   synchroniser, decodes the synchronised value to binary, and classifies each
//   change as one step up, one step down, or an illegal transition.
//
//   Optional feature macro: GREY_RX_ERRCNT_EN
//     When defined, adds the err_cnt port: an 8-bit saturating count of err
//     pulses, cleared only by rst_n.
//
// Parameters
//   WIDTH        gray/binary bus width (>= 2)
//   SYNC_STAGES  synchroniser flops per bit (>= 2)
//
// Ports
//   clk      in   1      consumer-domain clock, all logic on posedge
//   rst_n    in   1      asynchronous active-low reset
//   grey     in   WIDTH  gray-coded count, asynchronous to clk
//   bin      out  WIDTH  binary of the last accepted sample
//   valid    out  1      high once the first sample has been loaded
//   step_up  out  1      1-cycle pulse, bin advanced by +1 (mod 2^WIDTH)
//   step_dn  out  1      1-cycle pulse, bin moved by -1 (mod 2^WIDTH)
//   err      out  1      1-cycle pulse, illegal transition (relocked)
//   err_cnt  out  8      saturating error count (GREY_RX_ERRCNT_EN only)
// -----------------------------------------------------------------------------
module grey_code_rx #(
  parameter int WIDTH       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] grey,
  output logic [WIDTH-1:0] bin,
  output logic             valid,
  output logic             step_up,
  output logic             step_dn,
`ifdef GREY_RX_ERRCNT_EN
  output logic             err,
  output logic [7:0]       err_cnt
`else
  output logic             err
`endif
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [0:0] {
    ST_PRIME = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when exactly one bit of x is set (popcount == 1).
  function automatic logic one_hot(input logic [WIDTH-1:0] x);
    return (x != {WIDTH{1'b0}}) && ((x & (x - WIDTH'(1))) == {WIDTH{1'b0}});
  endfunction

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] prime_cnt_r;
  logic [CNT_W-1:0] prime_cnt_nxt_s;
  logic [WIDTH-1:0] g_q_r;
  logic [WIDTH-1:0] g_q_nxt_s;
  logic [WIDTH-1:0] bin_r;
  logic [WIDTH-1:0] bin_nxt_s;
  logic             valid_r;
  logic             valid_nxt_s;
  logic             step_up_r;
  logic             step_up_nxt_s;
  logic             step_dn_r;
  logic             step_dn_nxt_s;
  logic             err_r;
  logic             err_nxt_s;

  logic [WIDTH-1:0] samp_s;
  logic [WIDTH-1:0] dec_s;
  logic [WIDTH-1:0] diff_s;
  logic             one_bit_s;

  // Synchroniser chain: plain flops, no logic between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      sync_r[0] <= grey;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign samp_s    = sync_r[SYNC_STAGES-1];
  assign dec_s     = gray2bin(samp_s);
  // Modular distance from the accepted value; +1 and -1 (all ones) are steps.
  assign diff_s    = dec_s - bin_r;
  assign one_bit_s = one_hot(samp_s ^ g_q_r);

  // Next-state and next-output logic for the prime/track FSM.
  always_comb begin
    state_nxt_s     = state_r;
    prime_cnt_nxt_s = prime_cnt_r;
    g_q_nxt_s       = g_q_r;
    bin_nxt_s       = bin_r;
    valid_nxt_s     = valid_r;
    step_up_nxt_s   = 1'b0;
    step_dn_nxt_s   = 1'b0;
    err_nxt_s       = 1'b0;
    case (state_r)
      ST_PRIME: begin
        // Wait until the synchroniser holds a post-reset sample, then load
        // it silently.
        if (prime_cnt_r == CNT_W'(SYNC_STAGES)) begin
          g_q_nxt_s   = samp_s;
          bin_nxt_s   = dec_s;
          valid_nxt_s = 1'b1;
          state_nxt_s = ST_TRACK;
        end else begin
          prime_cnt_nxt_s = prime_cnt_r + CNT_W'(1);
        end
      end
      ST_TRACK: begin
        if (samp_s != g_q_r) begin
          // Any change is accepted; illegal ones relock to the new value.
          g_q_nxt_s = samp_s;
          bin_nxt_s = dec_s;
          if (one_bit_s && (diff_s == WIDTH'(1))) begin
            step_up_nxt_s = 1'b1;
          end else if (one_bit_s && (diff_s == {WIDTH{1'b1}})) begin
            step_dn_nxt_s = 1'b1;
          end else begin
            err_nxt_s = 1'b1;
          end
        end else begin
          g_q_nxt_s = g_q_r;
        end
      end
      default: begin
        state_nxt_s     = ST_PRIME;
        prime_cnt_nxt_s = {CNT_W{1'b0}};
        valid_nxt_s     = 1'b0;
      end
    endcase
  end

  // FSM state, accepted sample and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_PRIME;
      prime_cnt_r <= {CNT_W{1'b0}};
      g_q_r       <= {WIDTH{1'b0}};
      bin_r       <= {WIDTH{1'b0}};
      valid_r     <= 1'b0;
      step_up_r   <= 1'b0;
      step_dn_r   <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      prime_cnt_r <= prime_cnt_nxt_s;
      g_q_r       <= g_q_nxt_s;
      bin_r       <= bin_nxt_s;
      valid_r     <= valid_nxt_s;
      step_up_r   <= step_up_nxt_s;
      step_dn_r   <= step_dn_nxt_s;
      err_r       <= err_nxt_s;
    end
  end

  assign bin     = bin_r;
  assign valid   = valid_r;
  assign step_up = step_up_r;
  assign step_dn = step_dn_r;
  assign err     = err_r;

`ifdef GREY_RX_ERRCNT_EN
  logic [7:0] err_cnt_r;

  // Saturating error counter, updated together with the err pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 8'd0;
    end else if (err_nxt_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_grey_code_rx.sv
// -----------------------------------------------------------------------------
// tb_grey_code_rx
//   Scoreboard bench for grey_code_rx (WIDTH=6, SYNC_STAGES=2). The driver
//   classifies each gray change with plain arithmetic and queues the expected
//   event (kind, binary value, cycle); the monitor pops and compares whenever
//   the DUT raises valid or a pulse, and checks bin stays put otherwise.
// -----------------------------------------------------------------------------
module tb_grey_code_rx;

  localparam int W = 6;
  localparam int EV_LOAD = 0;
  localparam int EV_UP   = 1;
  localparam int EV_DN   = 2;
  localparam int EV_ERR  = 3;

  typedef struct {
    int         kind;
    logic [5:0] bin;
    int         cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] grey;
  logic [W-1:0] bin;
  logic         valid;
  logic         step_up;
  logic         step_dn;
  logic         err;
`ifdef GREY_RX_ERRCNT_EN
  logic [7:0]   err_cnt;
`endif

  grey_code_rx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .grey    (grey),
    .bin     (bin),
    .valid   (valid),
    .step_up (step_up),
    .step_dn (step_dn),
`ifdef GREY_RX_ERRCNT_EN
    .err     (err),
    .err_cnt (err_cnt)
`else
    .err     (err)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         passes = 0;
  int         cyc = 0;
  exp_t       sb_q[$];
  logic [5:0] model_g;
  int         model_errs;
  logic [5:0] hold_bin;
  bit         hold_known;
  bit         valid_prev;

  // Reference decode: binary bit i is the parity of gray bits i and above.
  function automatic logic [5:0] to_bin(input logic [5:0] g);
    logic [5:0] b;
    b = g;
    for (int k = 1; k < 6; k++) b = b ^ (g >> k);
    return b;
  endfunction

  function automatic logic [5:0] to_gray(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int classify(input logic [5:0] pg, input logic [5:0] ng);
    int d;
    d = (int'(to_bin(ng)) - int'(to_bin(pg)) + 64) % 64;
    if ($countones(pg ^ ng) == 1 && d == 1)  return EV_UP;
    if ($countones(pg ^ ng) == 1 && d == 63) return EV_DN;
    return EV_ERR;
  endfunction

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: count edges, sample 2 time units after each rising edge.
  always begin
    int   nev;
    int   kind;
    bit   rise;
    exp_t e;
    @(posedge clk);
    cyc++;
    #2;
    if (!rst_n) begin
      valid_prev = 1'b0;
      hold_known = 1'b0;
    end else begin
      rise = valid && !valid_prev;
      nev  = int'(rise) + int'(step_up) + int'(step_dn) + int'(err);
      if (nev > 0) begin
        if (nev > 1) check(1'b0, "exclusive_events", nev, 1);
        kind = rise ? EV_LOAD : step_up ? EV_UP : step_dn ? EV_DN : EV_ERR;
        if (sb_q.size() == 0) begin
          check(1'b0, "unexpected_event", kind, -1);
        end else begin
          e = sb_q.pop_front();
          check(kind == e.kind, "event_kind", kind, e.kind);
          check(bin == e.bin, "event_bin", int'(bin), int'(e.bin));
          check(cyc == e.cyc, "event_cycle", cyc, e.cyc);
          hold_bin   = e.bin;
          hold_known = 1'b1;
        end
      end else if (hold_known) begin
        check(valid && bin == hold_bin, "steady_bin", int'(bin), int'(hold_bin));
      end
      valid_prev = valid;
    end
  end

  task automatic apply(input logic [5:0] g, input int hold);
    exp_t e;
    @(negedge clk);
    if (g != model_g) begin
      e.kind = classify(model_g, g);
      e.bin  = to_bin(g);
      e.cyc  = cyc + 3;
      sb_q.push_back(e);
      if (e.kind == EV_ERR && model_errs < 255) model_errs++;
      model_g = g;
    end
    grey = g;
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      check(1'b0, "drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
`ifdef GREY_RX_ERRCNT_EN
    check(int'(err_cnt) == model_errs, "err_cnt", int'(err_cnt), model_errs);
`endif
  endtask

  task automatic do_reset(input logic [5:0] g);
    exp_t e;
    drain();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check(bin == 6'd0, "reset_bin", int'(bin), 0);
    check(valid == 1'b0, "reset_valid", int'(valid), 0);
    check({step_up, step_dn, err} == 3'b000, "reset_pulses", int'({step_up, step_dn, err}), 0);
    model_errs = 0;
`ifdef GREY_RX_ERRCNT_EN
    check(err_cnt == 8'd0, "reset_err_cnt", int'(err_cnt), 0);
`endif
    grey    = g;
    model_g = g;
    repeat (3) @(negedge clk);
    e.kind = EV_LOAD;
    e.bin  = to_bin(g);
    e.cyc  = cyc + 3;
    sb_q.push_back(e);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] g;
    logic [5:0] mb;
    int         r;
    rst_n      = 1'b0;
    grey       = 6'd0;
    model_g    = 6'd0;
    model_errs = 0;
    hold_bin   = 6'd0;
    hold_known = 1'b0;
    valid_prev = 1'b0;

    // Power-up with grey held at zero.
    do_reset(6'b000000);

    // Count up 1..4.
    apply(6'b000001, 4);
    apply(6'b000011, 4);
    apply(6'b000010, 4);
    apply(6'b000110, 4);

    // Wrap in both directions around 63/0.
    apply(6'b100000, 4);
    apply(6'b000000, 4);
    apply(6'b100000, 4);

    // Multi-bit jump 3 -> 6.
    apply(6'b000010, 4);
    apply(6'b000101, 4);

    // One-bit flip of the MSB that is not a unit step, then many of them.
    apply(6'b000001, 4);
    apply(6'b100001, 4);
    for (int i = 0; i < 300; i++) begin
      apply(6'b000001, 1);
      apply(6'b100001, 1);
    end
    drain();

    // Reset mid-operation with bin=5, reload at grey 000111.
    apply(6'b000111, 4);
    drain();
    do_reset(6'b000111);
    drain();

    // Randomised walk: mostly legal steps, with flips, jumps and holds.
    for (int i = 0; i < 400; i++) begin
      mb = to_bin(model_g);
      r  = int'($urandom_range(0, 9));
      if (r < 4)       g = to_gray(mb + 6'd1);
      else if (r < 7)  g = to_gray(mb - 6'd1);
      else if (r == 7) g = model_g ^ (6'd1 << $urandom_range(0, 5));
      else if (r == 8) g = 6'($urandom_range(0, 63));
      else             g = model_g;
      apply(g, int'($urandom_range(1, 4)));
      if (i == 200) do_reset(6'($urandom_range(0, 63)));
    end
    apply(model_g, 6);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
